des_ip_keysched: RTL and testbench

DES input stage: applies the initial permutation (IP) to a 64-bit block and runs the full key schedule (PC-1, per-round rotations, PC-2). Accepts one block/key pair per valid/ready handshake. Presents the permuted halves on a held block port and streams 16 round subkeys in encrypt or decrypt order. It sits between the input interface and the round datapath, and replaces the single-cycle IP/parity-drop stage.

---
 rtl/des_pkg.sv | 64 ++++++
 rtl/des_key_rot.sv | 32 +++
 rtl/des_ip_keysched.sv | 122 ++++++++++++
 tb/tb_des_ip_keysched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, key-rotation schedule, FSM encoding
// and bit-ordering helpers. DES bit n of an [N:1] vector lives at index N+1-n.
package des_pkg;

    localparam int DES_BLK_W  = 64;
    localparam int DES_HALF_W = 32;
    localparam int DES_CD_W   = 28;
    localparam int DES_SK_W   = 48;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit r set when round r rotates C/D by two places instead of one.
    localparam logic [16:1] SHIFT_TWO = 16'h7EFC;

    function automatic logic [DES_BLK_W:1] des_ip(input logic [DES_BLK_W:1] x);
        logic [DES_BLK_W:1] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[DES_BLK_W - i] = x[DES_BLK_W + 1 - IP_TBL[i]];
        return y;
    endfunction

    function automatic logic [2*DES_CD_W:1] des_pc1(input logic [DES_BLK_W:1] x);
        logic [2*DES_CD_W:1] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[2*DES_CD_W - i] = x[DES_BLK_W + 1 - PC1_TBL[i]];
        return y;
    endfunction

    function automatic logic [DES_SK_W:1] des_pc2(input logic [2*DES_CD_W:1] cd);
        logic [DES_SK_W:1] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[DES_SK_W - i] = cd[2*DES_CD_W + 1 - PC2_TBL[i]];
        return y;
    endfunction

    function automatic logic des_shift_two(input logic [4:0] round);
        logic [31:0] tbl;
        tbl = {15'b0, SHIFT_TWO, 1'b0};
        return tbl[round];
    endfunction

endpackage

// File: rtl/des_key_rot.sv
// Combinational C/D rotation (left or right, by one or two) with PC-2 of both
// the current and the rotated halves; shared with the round datapath.
module des_key_rot
    import des_pkg::*;
(
    input  logic [DES_CD_W:1] c_in,
    input  logic [DES_CD_W:1] d_in,
    input  logic              left,
    input  logic              two,
    output logic [DES_CD_W:1] c_out,
    output logic [DES_CD_W:1] d_out,
    output logic [DES_SK_W:1] sk_cur,
    output logic [DES_SK_W:1] sk_rot
);

    // Index 28 holds DES bit 1, so a DES left shift is a vector rotate toward the MSB.
    function automatic logic [DES_CD_W:1] rot(input logic [DES_CD_W:1] x,
                                               input logic l, input logic t);
        case ({l, t})
            2'b10:   rot = {x[27:1], x[28]};
            2'b11:   rot = {x[26:1], x[28:27]};
            2'b00:   rot = {x[1], x[28:2]};
            default: rot = {x[2:1], x[28:3]};
        endcase
    endfunction

    assign c_out  = rot(c_in, left, two);
    assign d_out  = rot(d_in, left, two);
    assign sk_cur = des_pc2({c_in, d_in});
    assign sk_rot = des_pc2({c_out, d_out});

endmodule

// File: rtl/des_ip_keysched.sv
// DES input stage: registers IP(data) and PC-1(key) on accept, holds L0/R0 on the
// block port and streams the 16 round subkeys in encrypt or decrypt order.
module des_ip_keysched
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b1,
    parameter bit DROP_ON_ERR  = 1'b0
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DES_BLK_W:1]    data,
    input  logic [DES_BLK_W:1]    key,
    input  logic                  decrypt,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [DES_HALF_W:1]   data_l,
    output logic [DES_HALF_W:1]   data_r,
    output logic [8:1]            parity_err,
    output logic                  sk_valid,
    input  logic                  sk_ready,
    output logic [DES_SK_W:1]     sk,
    output logic [5:1]            sk_round,
    output logic                  sk_last
);

    logic [0:0]           state, state_nx;
    logic [DES_CD_W:1]    c_q, d_q, c_rot, d_rot;
    logic [DES_SK_W:1]    sk_cur, sk_rot;
    logic [DES_BLK_W:1]   ip_nx;
    logic [2*DES_CD_W:1]  pc1_nx;
    logic [8:1]           perr_nx;
    logic [4:0]           cnt, round_idx;
    logic                 dec_q, blk_done, sk_done;
    logic                 accept, blk_hs, sk_hs, run_exit, shift_two;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        perr_nx = '0;
        if (PARITY_CHECK) begin
            for (int b = 1; b <= 8; b++) perr_nx[b] = ~^key[8*b -: 8];
        end
    end

    assign ip_nx  = des_ip(data);
    assign pc1_nx = des_pc1(key);

    assign blk_valid = (state == ST_RUN) && !blk_done;
    assign sk_valid  = (state == ST_RUN) && !sk_done;
    assign accept    = in_valid && in_ready;
    assign blk_hs    = blk_valid && blk_ready;
    assign sk_hs     = sk_valid && sk_ready;
    assign sk_last   = sk_valid && (cnt == 5'd15);

    // Decrypt walks C16..C1 backwards, and C16 equals C0 because the shifts total 28.
    assign round_idx = dec_q ? (5'd16 - cnt) : (cnt + 5'd1);
    assign sk_round  = sk_valid ? round_idx : '0;
    assign shift_two = des_shift_two(round_idx);
    assign sk        = dec_q ? sk_cur : sk_rot;

    des_key_rot u_key_rot (
        .c_in   (c_q),
        .d_in   (d_q),
        .left   (!dec_q),
        .two    (shift_two),
        .c_out  (c_rot),
        .d_out  (d_rot),
        .sk_cur (sk_cur),
        .sk_rot (sk_rot)
    );

    assign run_exit = (state == ST_RUN) && (blk_done || blk_hs) && (sk_done || (sk_hs && sk_last));

    always_comb begin
        state_nx = state;
        if (accept)        state_nx = ST_RUN;
        else if (run_exit) state_nx = ST_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; datapath registers are
    // reset too so the held outputs read zero rather than stale keys after a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_ready   <= 1'b0;
            data_l     <= '0;
            data_r     <= '0;
            c_q        <= '0;
            d_q        <= '0;
            dec_q      <= 1'b0;
            parity_err <= '0;
            cnt        <= '0;
            blk_done   <= 1'b0;
            sk_done    <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx == ST_IDLE);
            if (accept) begin
                data_l     <= ip_nx[64:33];
                data_r     <= ip_nx[32:1];
                c_q        <= pc1_nx[56:29];
                d_q        <= pc1_nx[28:1];
                dec_q      <= decrypt;
                parity_err <= perr_nx;
                cnt        <= '0;
                blk_done   <= 1'b0;
                sk_done    <= DROP_ON_ERR && (perr_nx != '0);
            end else begin
                if (blk_hs) blk_done <= 1'b1;
                if (sk_hs) begin
                    c_q <= c_rot;
                    d_q <= d_rot;
                    cnt <= cnt + 5'd1;
                    if (sk_last) sk_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_des_ip_keysched.sv
// Self-checking bench for des_ip_keysched: known-answer vectors, randomized blocks
// with random stalls, parity drop, mid-stream reset and in_valid during RUN.
module tb_des_ip_keysched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, decrypt;
    logic        blk_valid, blk_ready, sk_valid, sk_ready, sk_last;
    logic [64:1] data, key;
    logic [32:1] data_l, data_r;
    logic [8:1]  parity_err;
    logic [48:1] sk;
    logic [5:1]  sk_round;

    logic        in_valid2, in_ready2, blk_valid2, blk_ready2, sk_valid2, sk_ready2, sk_last2;
    logic [32:1] data_l2, data_r2;
    logic [8:1]  parity_err2;
    logic [48:1] sk2;
    logic [5:1]  sk_round2;

    des_ip_keysched #(.PARITY_CHECK(1'b1), .DROP_ON_ERR(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .key(key), .decrypt(decrypt),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .data_l(data_l), .data_r(data_r),
        .parity_err(parity_err), .sk_valid(sk_valid), .sk_ready(sk_ready),
        .sk(sk), .sk_round(sk_round), .sk_last(sk_last)
    );

    des_ip_keysched #(.PARITY_CHECK(1'b1), .DROP_ON_ERR(1'b1)) dut_drop (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .data(data), .key(key), .decrypt(decrypt),
        .blk_valid(blk_valid2), .blk_ready(blk_ready2), .data_l(data_l2), .data_r(data_r2),
        .parity_err(parity_err2), .sk_valid(sk_valid2), .sk_ready(sk_ready2),
        .sk(sk2), .sk_round(sk_round2), .sk_last(sk_last2)
    );

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [64:1] KAT_D    = 64'h0123456789ABCDEF;
    localparam logic [64:1] KAT_K    = 64'h133457799BBCDFF1;
    localparam logic [64:1] KEY_BAD  = 64'h133457799BBCDFF0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [32:1] exp_l, exp_r;
    logic [8:1]  exp_pe;
    logic [48:1] exp_sk [16];
    logic [5:1]  exp_rnd [16];

    logic [32:1] obs_l, obs_r;
    logic [8:1]  obs_pe;
    logic [48:1] obs_first_sk, obs_last_sk;
    logic [5:1]  obs_first_rnd, obs_last_rnd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
        end
    endtask

    // Reference: subkey r is PC-2 of C0/D0 each rotated left by the running sum of shifts.
    task automatic build_model(input logic [64:1] d, input logic [64:1] k, input logic dec);
        bit db [1:64];
        bit kb [1:64];
        bit c0 [1:28];
        bit d0 [1:28];
        bit cd [1:56];
        logic [48:1] kr;
        int s, ones, pos;
        for (int n = 1; n <= 64; n++) begin
            db[n] = d[65-n];
            kb[n] = k[65-n];
        end
        for (int i = 1; i <= 32; i++) begin
            exp_l[33-i] = db[IP_T[i-1]];
            exp_r[33-i] = db[IP_T[31+i]];
        end
        for (int b = 1; b <= 8; b++) begin
            ones = 0;
            for (int j = 0; j < 8; j++) ones += int'(kb[65 - 8*b + j]);
            exp_pe[b] = (ones % 2 == 0);
        end
        for (int j = 1; j <= 28; j++) begin
            c0[j] = kb[PC1_T[j-1]];
            d0[j] = kb[PC1_T[27+j]];
        end
        s = 0;
        for (int r = 1; r <= 16; r++) begin
            s += SH_T[r-1];
            for (int j = 1; j <= 28; j++) begin
                cd[j]      = c0[((j - 1 + s) % 28) + 1];
                cd[28 + j] = d0[((j - 1 + s) % 28) + 1];
            end
            for (int i = 1; i <= 48; i++) kr[49-i] = cd[PC2_T[i-1]];
            pos = dec ? 16 - r : r - 1;
            exp_sk[pos]  = kr;
            exp_rnd[pos] = 5'(r);
        end
    endtask

    // mode 0: readies held high; mode 1: blk_ready low 30 cycles, then both random.
    task automatic run_block(input logic [64:1] d_in, input logic [64:1] k_in, input logic dec_in,
                             input int mode, input bit pulse, input string tag);
        int idx, cyc, w;
        bit blk_seen, hs_sk, hs_blk;
        build_model(d_in, k_in, dec_in);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_in_ready_idle"}, in_ready, 1);
        data = d_in; key = k_in; decrypt = dec_in; in_valid = 1'b1;
        blk_ready = (mode == 0);
        sk_ready  = (mode == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data = {$urandom, $urandom};
        key = {$urandom, $urandom};
        decrypt = ~dec_in;
        check({tag, "_first_round"}, sk_round, exp_rnd[0]);
        idx = 0; cyc = 0; blk_seen = 0;
        while ((idx < 16 || !blk_seen) && cyc < 400) begin
            check({tag, "_in_ready_busy"}, in_ready, 0);
            check({tag, "_blk_valid"}, blk_valid, !blk_seen);
            check({tag, "_sk_valid"}, sk_valid, idx < 16);
            if (blk_valid) begin
                check({tag, "_data_l"}, data_l, exp_l);
                check({tag, "_data_r"}, data_r, exp_r);
                check({tag, "_parity"}, parity_err, exp_pe);
                obs_l = data_l; obs_r = data_r; obs_pe = parity_err;
            end
            if (sk_valid && idx < 16) begin
                check({tag, "_sk"}, sk, exp_sk[idx]);
                check({tag, "_sk_round"}, sk_round, exp_rnd[idx]);
                check({tag, "_sk_last"}, sk_last, idx == 15);
                if (idx == 0) begin obs_first_sk = sk; obs_first_rnd = sk_round; end
                if (idx == 15) begin obs_last_sk = sk; obs_last_rnd = sk_round; end
            end
            if (mode == 1) begin
                blk_ready = (cyc >= 30) && ($urandom_range(0, 1) == 1);
                sk_ready  = ($urandom_range(0, 1) == 1);
            end
            if (pulse) begin
                in_valid = (cyc == 2 || cyc == 3);
                if (in_valid) begin
                    data = {$urandom, $urandom};
                    key = {$urandom, $urandom};
                    decrypt = ($urandom_range(0, 1) == 1);
                end
            end
            hs_sk  = sk_valid && sk_ready;
            hs_blk = blk_valid && blk_ready;
            @(posedge clk); #1;
            if (hs_sk) idx++;
            if (hs_blk) blk_seen = 1;
            cyc++;
        end
        in_valid = 1'b0; blk_ready = 1'b0; sk_ready = 1'b0;
        check({tag, "_sk_count"}, idx, 16);
        check({tag, "_blk_taken"}, blk_seen, 1);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_blk_valid_after"}, blk_valid, 0);
        check({tag, "_sk_valid_after"}, sk_valid, 0);
        if (mode == 0) check({tag, "_cycles"}, cyc, 16);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; blk_ready = 1'b0; sk_ready = 1'b0;
        in_valid2 = 1'b0; blk_ready2 = 1'b0; sk_ready2 = 1'b0;
        data = '0; key = '0; decrypt = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_sk_valid", sk_valid, 0);
        check("rst_sk_last", sk_last, 0);
        check("rst_data_l", data_l, 0);
        check("rst_data_r", data_r, 0);
        check("rst_sk", sk, 0);
        check("rst_parity", parity_err, 0);
        check("rst_sk_round", sk_round, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_in_ready", in_ready, 1);

        run_block(KAT_D, KAT_K, 1'b0, 0, 1'b0, "kat_enc");
        check("kat_enc_l", obs_l, 32'hCC00CCFF);
        check("kat_enc_r", obs_r, 32'hF0AAF0AA);
        check("kat_enc_pe", obs_pe, 8'h00);
        check("kat_enc_first", obs_first_sk, 48'h1B02EFFC7072);
        check("kat_enc_first_rnd", obs_first_rnd, 5'd1);
        check("kat_enc_last", obs_last_sk, 48'hCB3D8B0E17F5);
        check("kat_enc_last_rnd", obs_last_rnd, 5'd16);

        run_block(KAT_D, KAT_K, 1'b1, 0, 1'b0, "kat_dec");
        check("kat_dec_first", obs_first_sk, 48'hCB3D8B0E17F5);
        check("kat_dec_first_rnd", obs_first_rnd, 5'd16);
        check("kat_dec_last", obs_last_sk, 48'h1B02EFFC7072);
        check("kat_dec_last_rnd", obs_last_rnd, 5'd1);

        run_block(KAT_D, KEY_BAD, 1'b0, 0, 1'b0, "bad_keep");
        check("bad_keep_pe", obs_pe, 8'h01);

        build_model(KAT_D, KEY_BAD, 1'b0);
        data = KAT_D; key = KEY_BAD; decrypt = 1'b0;
        check("drop_in_ready_idle", in_ready2, 1);
        in_valid2 = 1'b1; sk_ready2 = 1'b1; blk_ready2 = 1'b0;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("drop_parity", parity_err2, exp_pe);
        check("drop_data_l", data_l2, exp_l);
        check("drop_data_r", data_r2, exp_r);
        for (int i = 0; i < 5; i++) begin
            check("drop_blk_valid", blk_valid2, 1);
            check("drop_sk_valid", sk_valid2, 0);
            check("drop_sk_last", sk_last2, 0);
            check("drop_in_ready_busy", in_ready2, 0);
            @(posedge clk); #1;
        end
        blk_ready2 = 1'b1;
        @(posedge clk); #1;
        blk_ready2 = 1'b0; sk_ready2 = 1'b0;
        check("drop_blk_valid_after", blk_valid2, 0);
        check("drop_sk_valid_after", sk_valid2, 0);
        check("drop_in_ready_after", in_ready2, 1);

        for (int t = 0; t < 4; t++)
            run_block({$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 1) == 1),
                      1, 1'b0, "stall");

        build_model(KAT_D, KAT_K, 1'b0);
        data = KAT_D; key = KAT_K; decrypt = 1'b0;
        in_valid = 1'b1; blk_ready = 1'b0; sk_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("mid_rst_pre_sk", sk, exp_sk[i]);
            @(posedge clk); #1;
        end
        check("mid_rst_pre_round", sk_round, 5'd6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; sk_ready = 1'b0;
        check("mid_rst_blk_valid", blk_valid, 0);
        check("mid_rst_sk_valid", sk_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("mid_rst_in_ready_rel", in_ready, 1);
        check("mid_rst_sk_valid_rel", sk_valid, 0);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 1'b0, "post_rst");

        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1, 1'b1, "pulse_enc");
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1, 1'b1, "pulse_dec");

        for (int t = 0; t < 3; t++)
            run_block({$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 1) == 1),
                      0, 1'b0, "b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
